io_timer: RTL and testbench

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_timer.sv | 145 ++++++++++++++
 tb/tb_io_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_timer.sv
// io_timer: bus-mapped 64-bit machine timer with 16-bit prescaler and compare interrupt.
// Optional feature: define IO_TIMER_SNAPSHOT_EN to latch MTIME_HI on every MTIME_LO read.
module io_timer #(
  parameter int XLEN         = 32,
  parameter int PRESCALE_RST = 0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [15:0]       io_addr,
  input  logic              io_rd_req,
  input  logic              io_wr_req,
  input  logic [XLEN/8-1:0] io_be,
  input  logic [XLEN-1:0]   io_wr_data,
  output logic [XLEN-1:0]   io_rd_data,
  output logic              io_rd_ready,
  output logic              io_wr_ready,
  output logic              timer_irq
);
  localparam int NB = XLEN / 8;

  logic [63:0]     mtime_reg, mtime_next;
  logic [63:0]     mtimecmp_reg, mtimecmp_next;
  logic [1:0]      ctrl_reg, ctrl_next;
  logic [15:0]     prescale_reg, prescale_next;
  logic [15:0]     cnt_reg, cnt_next;
  logic            rd_ready_reg, wr_ready_reg, irq_reg;
  logic [XLEN-1:0] rd_data_reg;
  logic [31:0]     rd_val;
  logic [31:0]     wmask, wdata;
  logic [31:0]     m_lo, m_hi, c_lo, c_hi;
  logic [5:0]      wr_sel;
  logic [2:0]      idx;
  logic            mapped, rd_fire, wr_fire, tick;
  logic            unused_addr;

  assign idx         = io_addr[4:2];
  assign mapped      = (io_addr[15:5] == 11'd0);
  assign unused_addr = ^io_addr[1:0];

  // A pending write always wins; reads wait until the write request is gone.
  assign wr_fire = io_wr_req & ~wr_ready_reg;
  assign rd_fire = io_rd_req & ~io_wr_req & ~rd_ready_reg;
  assign tick    = ctrl_reg[0] & (cnt_reg == prescale_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      if (gi < NB) begin : g_used
        assign wmask[gi*8 +: 8] = {8{io_be[gi]}};
        assign wdata[gi*8 +: 8] = io_wr_data[gi*8 +: 8];
      end else begin : g_unused
        assign wmask[gi*8 +: 8] = 8'h00;
        assign wdata[gi*8 +: 8] = 8'h00;
      end
    end
    for (gi = 0; gi < 6; gi++) begin : g_sel
      assign wr_sel[gi] = wr_fire & mapped & (idx == 3'(gi));
    end
  endgenerate

  assign m_lo = (mtime_reg[31:0]     & ~wmask) | (wdata & wmask);
  assign m_hi = (mtime_reg[63:32]    & ~wmask) | (wdata & wmask);
  assign c_lo = (mtimecmp_reg[31:0]  & ~wmask) | (wdata & wmask);
  assign c_hi = (mtimecmp_reg[63:32] & ~wmask) | (wdata & wmask);

  always_comb begin
    mtime_next    = mtime_reg;
    mtimecmp_next = mtimecmp_reg;
    ctrl_next     = ctrl_reg;
    prescale_next = prescale_reg;
    cnt_next      = cnt_reg;
    if (ctrl_reg[0]) cnt_next = tick ? 16'd0 : cnt_reg + 16'd1;
    // A software write to MTIME replaces that cycle's increment entirely.
    if (wr_sel[0] | wr_sel[1]) begin
      if (wr_sel[0]) mtime_next[31:0]  = m_lo;
      if (wr_sel[1]) mtime_next[63:32] = m_hi;
    end else if (tick) begin
      mtime_next = mtime_reg + 64'd1;
    end
    if (wr_sel[2]) mtimecmp_next[31:0]  = c_lo;
    if (wr_sel[3]) mtimecmp_next[63:32] = c_hi;
    if (wr_sel[4]) ctrl_next = (ctrl_reg & ~wmask[1:0]) | (wdata[1:0] & wmask[1:0]);
    if (wr_sel[5]) begin
      prescale_next = (prescale_reg & ~wmask[15:0]) | (wdata[15:0] & wmask[15:0]);
      cnt_next      = 16'd0;
    end
  end

`ifdef IO_TIMER_SNAPSHOT_EN
  logic [31:0] snap_reg;

  always_ff @(posedge clk) begin
    if (!rstb) snap_reg <= 32'd0;
    else if (rd_fire && mapped && idx == 3'd0) snap_reg <= mtime_reg[63:32];
  end
`endif

  always_comb begin
    rd_val = 32'd0;
    if (mapped) begin
      case (idx)
        3'd0:    rd_val = mtime_reg[31:0];
`ifdef IO_TIMER_SNAPSHOT_EN
        3'd1:    rd_val = snap_reg;
`else
        3'd1:    rd_val = mtime_reg[63:32];
`endif
        3'd2:    rd_val = mtimecmp_reg[31:0];
        3'd3:    rd_val = mtimecmp_reg[63:32];
        3'd4:    rd_val = {30'd0, ctrl_reg};
        3'd5:    rd_val = {16'd0, prescale_reg};
        default: rd_val = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      mtime_reg    <= 64'd0;
      mtimecmp_reg <= {64{1'b1}};
      ctrl_reg     <= 2'd0;
      prescale_reg <= 16'(PRESCALE_RST);
      cnt_reg      <= 16'd0;
      rd_ready_reg <= 1'b0;
      wr_ready_reg <= 1'b0;
      rd_data_reg  <= '0;
      irq_reg      <= 1'b0;
    end else begin
      mtime_reg    <= mtime_next;
      mtimecmp_reg <= mtimecmp_next;
      ctrl_reg     <= ctrl_next;
      prescale_reg <= prescale_next;
      cnt_reg      <= cnt_next;
      rd_ready_reg <= rd_fire;
      wr_ready_reg <= wr_fire;
      if (rd_fire) rd_data_reg <= XLEN'(rd_val);
      irq_reg      <= ctrl_reg[0] & ctrl_reg[1] & (mtime_reg >= mtimecmp_reg);
    end
  end

  assign io_rd_data  = rd_data_reg;
  assign io_rd_ready = rd_ready_reg;
  assign io_wr_ready = wr_ready_reg;
  assign timer_irq   = irq_reg;
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed register-level test of io_timer with hand-computed expectations.
module tb_io_timer;
  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [15:0] io_addr = 16'h0;
  logic        io_rd_req = 1'b0;
  logic        io_wr_req = 1'b0;
  logic [3:0]  io_be = 4'h0;
  logic [31:0] io_wr_data = 32'h0;
  logic [31:0] io_rd_data;
  logic        io_rd_ready, io_wr_ready, timer_irq;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [15:0] A_MLO  = 16'h0000;
  localparam logic [15:0] A_MHI  = 16'h0004;
  localparam logic [15:0] A_CLO  = 16'h0008;
  localparam logic [15:0] A_CHI  = 16'h000C;
  localparam logic [15:0] A_CTRL = 16'h0010;
  localparam logic [15:0] A_PRE  = 16'h0014;

  always #5 clk = ~clk;

  io_timer #(.XLEN(32), .PRESCALE_RST(0)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .io_addr    (io_addr),
    .io_rd_req  (io_rd_req),
    .io_wr_req  (io_wr_req),
    .io_be      (io_be),
    .io_wr_data (io_wr_data),
    .io_rd_data (io_rd_data),
    .io_rd_ready(io_rd_ready),
    .io_wr_ready(io_wr_ready),
    .timer_irq  (timer_irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    io_rd_req = 1'b0;
    io_wr_req = 1'b0;
    rstb      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // The write lands on the edge where io_wr_ready rises; returns 1 ns after it.
  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
    int n = 0;
    io_addr = addr; io_wr_data = data; io_be = be; io_wr_req = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!io_wr_ready && n < 20);
    io_wr_req = 1'b0;
    if (!io_wr_ready) check("wr_timeout", 64'd0, 64'd1);
    $display("wr addr=0x%04h data=0x%08h be=%b cycles=%0d", addr, data, be, n);
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [31:0] data, output int cyc);
    cyc = 0;
    io_addr = addr; io_rd_req = 1'b1;
    do begin @(posedge clk); #1; cyc++; end while (!io_rd_ready && cyc < 20);
    io_rd_req = 1'b0;
    if (!io_rd_ready) check("rd_timeout", 64'd0, 64'd1);
    data = io_rd_data;
    $display("rd addr=0x%04h data=0x%08h cycles=%0d", addr, data, cyc);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_snap_hi;
    int cyc;

    do_reset();
    check("rst_rd_ready", io_rd_ready, 1'b0);
    check("rst_wr_ready", io_wr_ready, 1'b0);
    check("rst_rd_data", io_rd_data, 32'h0);
    check("rst_irq", timer_irq, 1'b0);
    rstb = 1'b1;
    $display("reset released");

    bus_read(A_CTRL, d, cyc);
    check("ctrl_rst", d, 32'h0);
    check("rd_latency", cyc, 1);
    @(posedge clk); #1;
    check("rd_pulse_fall", io_rd_ready, 1'b0);
    bus_read(A_CLO, d, cyc);
    check("cmp_lo_rst", d, 32'hFFFF_FFFF);
    bus_read(A_CHI, d, cyc);
    check("cmp_hi_rst", d, 32'hFFFF_FFFF);
    bus_read(A_PRE, d, cyc);
    check("prescale_rst", d, 32'h0);

    // Byte enables and held-write toggle
    bus_write(A_CTRL, 32'hAABB_CCDD, 4'b0001);
    bus_read(A_CTRL, d, cyc);
    check("ctrl_be_mask", d, 32'h1);
    io_addr = A_CTRL; io_wr_data = 32'h0; io_be = 4'b0001; io_wr_req = 1'b1;
    check("toggle_0", io_wr_ready, 1'b0);
    @(posedge clk); #1; check("toggle_1", io_wr_ready, 1'b1);
    @(posedge clk); #1; check("toggle_2", io_wr_ready, 1'b0);
    @(posedge clk); #1; check("toggle_3", io_wr_ready, 1'b1);
    io_wr_req = 1'b0;
    $display("held write to CTRL released");
    bus_read(A_CTRL, d, cyc);
    check("ctrl_cleared", d, 32'h0);
    bus_write(A_CTRL, 32'hFFFF_FFFF, 4'b0010);
    bus_read(A_CTRL, d, cyc);
    check("ctrl_lane1_only", d, 32'h0);

    // Unmapped space and ignored low address bits
    bus_write(A_MLO, 32'h0000_1234, 4'hF);
    bus_write(16'h0020, 32'hDEAD_BEEF, 4'hF);
    bus_read(A_MLO, d, cyc);
    check("unmapped_wr_noeffect", d, 32'h0000_1234);
    bus_read(16'h0020, d, cyc);
    check("unmapped_rd_hi", d, 32'h0);
    bus_read(16'h0018, d, cyc);
    check("unmapped_rd_idx6", d, 32'h0);
    bus_write(16'h001C, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_PRE, d, cyc);
    check("unmapped_idx7_noeffect", d, 32'h0);

    // Simultaneous read and write: write first, read held off
    io_addr = A_PRE; io_wr_data = 32'h7; io_be = 4'hF;
    io_wr_req = 1'b1; io_rd_req = 1'b1;
    @(posedge clk); #1;
    check("both_wr_ready", io_wr_ready, 1'b1);
    check("both_rd_held", io_rd_ready, 1'b0);
    io_wr_req = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!io_rd_ready && cyc < 10);
    check("both_rd_done", io_rd_ready, 1'b1);
    check("both_rd_data", io_rd_data, 32'h7);
    io_rd_req = 1'b0;
    $display("simultaneous rd/wr done cycles=%0d", cyc);
    @(posedge clk); #1;
    bus_read(16'h0017, d, cyc);
    check("addr_low_bits_ignored", d, 32'h7);

    // Prescaler rate: 40 enabled cycles at PRESCALE=3 -> 10 ticks, 8 more -> 2
    do_reset();
    rstb = 1'b1;
    bus_write(A_PRE, 32'h3, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    repeat (39) @(posedge clk);
    #1;
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_read(A_MLO, d, cyc);
    check("prescale3_40cyc", d, 32'd10);
    bus_write(A_CTRL, 32'h1, 4'hF);
    repeat (7) @(posedge clk);
    #1;
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_read(A_MLO, d, cyc);
    check("prescale3_period", d, 32'd12);

    // LO->HI carry; back-to-back enable/disable gives exactly two increments
    bus_write(A_PRE, 32'h0, 4'hF);
    bus_write(A_MLO, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_MHI, 32'h0, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_read(A_MLO, d, cyc);
    check("carry_lo", d, 32'h0);
    bus_read(A_MHI, d, cyc);
    check("carry_hi", d, 32'h1);

    bus_write(A_MLO, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_MHI, 32'hFFFF_FFFF, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_read(A_MLO, d, cyc);
    check("wrap_lo", d, 32'h0);
    bus_read(A_MHI, d, cyc);
    check("wrap_hi", d, 32'h0);

    // Write during increment: 0x100 -> 0x101 -> lane1 write 0xAA01 (no inc) -> 0xAA03
    bus_write(A_MLO, 32'h0000_0100, 4'hF);
    bus_write(A_MHI, 32'h0, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_write(A_MLO, 32'h0000_AA00, 4'b0010);
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_read(A_MLO, d, cyc);
    check("wr_drops_inc", d, 32'h0000_AA03);

    // Compare interrupt
    bus_write(A_MLO, 32'h0, 4'hF);
    bus_write(A_MHI, 32'h0, 4'hF);
    bus_write(A_CHI, 32'h0, 4'hF);
    bus_write(A_CLO, 32'd20, 4'hF);
    bus_write(A_CTRL, 32'h3, 4'hF);
    repeat (19) @(posedge clk);
    #1; check("irq_mtime19", timer_irq, 1'b0);
    @(posedge clk); #1; check("irq_mtime20_same", timer_irq, 1'b0);
    @(posedge clk); #1; check("irq_rise", timer_irq, 1'b1);
    $display("irq observed after compare match");
    bus_write(A_CLO, 32'hFFFF_FFFF, 4'hF);
    check("irq_still_high", timer_irq, 1'b1);
    @(posedge clk); #1; check("irq_drop", timer_irq, 1'b0);
    bus_write(A_CHI, 32'hFFFF_FFFF, 4'hF);
    check("irq_stays_low", timer_irq, 1'b0);
    bus_write(A_CTRL, 32'h0, 4'hF);

    // LO read then HI read straddling the carry
`ifdef IO_TIMER_SNAPSHOT_EN
    exp_snap_hi = 32'h0;
`else
    exp_snap_hi = 32'h1;
`endif
    bus_write(A_MLO, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_MHI, 32'h0, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_read(A_MLO, d, cyc);
    check("snap_lo", d, 32'hFFFF_FFFE);
    bus_read(A_MHI, d, cyc);
    check("snap_hi", d, exp_snap_hi);
    bus_write(A_CTRL, 32'h0, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
